// File: rtl/vec_pack.sv
// Stream packer: strips the pad bits from each separated vector's final sub-vector
// and emits the vector bits back-to-back, MSB-first, in dense bus words.
module vec_pack #(
    parameter int BUS_WIDTH    = 128,
    parameter int VECTOR_WIDTH = 920,
    parameter int SUB_VEC_NO   = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [BUS_WIDTH-1:0] up_Vector,
    input  logic                 up_Valid,
    input  logic                 up_Last,
    output logic                 up_Ready,
    output logic [BUS_WIDTH-1:0] dn_Vector,
    output logic                 dn_Valid,
    output logic                 dn_Last,
    input  logic                 dn_Ready
);
    localparam int DELTA = SUB_VEC_NO * BUS_WIDTH - VECTOR_WIDTH;
    localparam int AW    = 2 * BUS_WIDTH;
    localparam int FW    = $clog2(AW) + 1;
    localparam int SW    = (SUB_VEC_NO > 1) ? $clog2(SUB_VEC_NO) : 1;

    localparam logic [FW-1:0]        BW_F     = FW'(BUS_WIDTH);
    localparam logic [FW-1:0]        LAST_N   = FW'(BUS_WIDTH - DELTA);
    localparam logic [SW-1:0]        SV_MAX   = SW'(SUB_VEC_NO - 1);
    localparam logic [BUS_WIDTH-1:0] PAD_MASK = {BUS_WIDTH{1'b1}} << DELTA;

    typedef enum logic {RUN, FLUSH} state_t;

    // Handshake: a word moves on either side only on a cycle where valid and ready
    // are both high; dn_* hold steady while dn_Valid is high and dn_Ready is low.

    state_t               state_q, state_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic [SW-1:0]        sv_q, sv_d;
    logic [BUS_WIDTH-1:0] dn_vector_q, dn_vector_d;
    logic                 dn_valid_q, dn_valid_d;
    logic                 dn_last_q, dn_last_d;

    logic                 out_free;
    logic                 load;
    logic [BUS_WIDTH-1:0] beat;
    logic [FW-1:0]        n;
    logic [FW-1:0]        t;
    logic [AW-1:0]        acc_in;

    assign dn_Vector = dn_vector_q;
    assign dn_Valid  = dn_valid_q;
    assign dn_Last   = dn_last_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        sv_d        = sv_q;
        dn_vector_d = dn_vector_q;
        dn_valid_d  = dn_valid_q;
        dn_last_d   = dn_last_q;
        load        = 1'b0;

        out_free = !dn_valid_q || dn_Ready;
        up_Ready = (state_q == RUN) && out_free;

        // Pad bits are masked to zero so the new beat can simply be OR-ed below the fill.
        beat   = (sv_q == SV_MAX) ? (up_Vector & PAD_MASK) : up_Vector;
        n      = (sv_q == SV_MAX) ? LAST_N : BW_F;
        t      = fill_q + n;
        acc_in = acc_q | ({beat, {BUS_WIDTH{1'b0}}} >> fill_q);

        if (dn_valid_q && dn_Ready) begin
            dn_valid_d = 1'b0;
        end

        if (state_q == RUN) begin
            if (up_Valid && up_Ready) begin
                sv_d = (up_Last || sv_q == SV_MAX) ? '0 : sv_q + 1'b1;
                if (t >= BW_F) begin
                    load        = 1'b1;
                    dn_vector_d = acc_in[AW-1 -: BUS_WIDTH];
                    dn_last_d   = up_Last && (t == BW_F);
                    acc_d       = acc_in << BUS_WIDTH;
                    fill_d      = t - BW_F;
                    if (up_Last && (t != BW_F)) begin
                        state_d = FLUSH;
                    end
                end else if (up_Last) begin
                    load        = 1'b1;
                    dn_vector_d = acc_in[AW-1 -: BUS_WIDTH];
                    dn_last_d   = 1'b1;
                    acc_d       = '0;
                    fill_d      = '0;
                end else begin
                    acc_d  = acc_in;
                    fill_d = t;
                end
            end
        end else if (out_free) begin
            // Residual bits of the batch; everything below the fill is already zero.
            load        = 1'b1;
            dn_vector_d = acc_q[AW-1 -: BUS_WIDTH];
            dn_last_d   = 1'b1;
            acc_d       = '0;
            fill_d      = '0;
            state_d     = RUN;
        end

        if (load) begin
            dn_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= RUN;
            acc_q       <= '0;
            fill_q      <= '0;
            sv_q        <= '0;
            dn_vector_q <= '0;
            dn_valid_q  <= 1'b0;
            dn_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            sv_q        <= sv_d;
            dn_vector_q <= dn_vector_d;
            dn_valid_q  <= dn_valid_d;
            dn_last_q   <= dn_last_d;
        end
    end
endmodule
